hyst_stream: RTL
================

// Module: hyst_stream
// PURPOSE
//  Streaming hysteresis-threshold stage of the edge pipeline, following non-max suppression.
//  Per beat: classifies the centre magnitude of a 3x3 window as edge (255) or non-edge (0).
//  Uses run-time low/high thresholds and a selectable neighbour mode.
//  2-stage valid/ready pipeline; per-frame edge and strong-pixel statistics.
// PARAMETERS
//  BITS         8    magnitude / threshold width
//  LOW_DEFAULT  25   low threshold after reset
//  HIGH_DEFAULT 50   high threshold after reset
//  CNT_BITS     20   width of per-frame statistic counters (saturating)
// PORTS
//  clk          in   1          system clock, rising edge
//  rst          in   1          asynchronous reset, active-high
//  cfg_we       in   1          write pending config this cycle
//  cfg_low      in   BITS       pending low threshold
//  cfg_high     in   BITS       pending high threshold
//  cfg_mode     in   2          0 angle-pair, 1 any-of-8, 2 strong-only, 3 = treated as 0
//  cfg_err      out  1          1-cycle pulse: write rejected (cfg_low > cfg_high)
//  in_valid     in   1          input beat valid
//  in_ready     out  1          input beat accepted when in_valid & in_ready
//  in_mag       in   9xBITS     3x3 window, row-major, index 4 = centre
//  in_angle     in   2          quantised gradient direction of centre
//  in_last      in   1          last pixel of frame
//  out_valid    out  1          output beat valid
//  out_ready    in   1          downstream accept
//  out_pixel    out  8          255 edge / 0 non-edge
//  out_last     out  1          in_last delayed with its beat
//  frame_done   out  1          1-cycle pulse when out_last beat is accepted
//  stat_edges   out  CNT_BITS   edge count of last completed frame
//  stat_strong  out  CNT_BITS   centre>=high count of last completed frame
// BEHAVIOUR
//  Reset: pipeline empty; out_valid=0, out_pixel=0, out_last=0, frame_done=0, cfg_err=0, stat_*=0.
//  Reset: pending and active cfg = LOW_DEFAULT/HIGH_DEFAULT/mode 0; frame_start=1.
//  Handshake: en2 = !out_valid | out_ready; en1 = !s1_valid | en2; in_ready = en1 (comb.).
//  Latency 2 cycles accept->out_valid when unstalled; full throughput 1 beat/cycle.
//  out_* hold stable while out_valid & !out_ready; no beat dropped or duplicated.
//  Stage 1 registers compare flags: c_hi = mag[4]>=high, c_lo = mag[4]>=low.
//  Stage 1 also registers nb_hi[8] (mag[i]>=high), angle, last.
//  Stage 2 edge = c_hi | (c_lo & N). All compares unsigned, inclusive (>=).
//  N, mode 0: angle pair high -> 0:{3,5} 1:{2,6} 2:{1,7} 3:{0,8}; N = either >=high.
//  N, mode 1: any of indices {0..3,5..8} >= high. Mode 2: N=0.
//  Config: cfg_we with cfg_low<=cfg_high loads pending regs; else ignored + cfg_err pulse.
//  Active cfg <- pending on the accept of the first beat of a frame (frame_start=1).
//    That beat already uses the new values; pending value is the registered value
//    (cfg_we in the same cycle applies from the next frame).
//  frame_start set by reset and by accept of an in_last beat; cleared by any other accept.
//  Active cfg never changes mid-frame.
//  Stats: counters advance on output accept (out_valid & out_ready).
//    Edge counter +1 if out_pixel=255; strong counter +1 if c_hi; both saturate at all-ones.
//  On accepting an out_last beat:
//    - stat_* <- counts including that beat; internal counters cleared;
//    - frame_done=1 for one cycle.
//  rst mid-frame: pipeline flushed, partial stats discarded, cfg returns to defaults.
// TESTING
//  1 mode0, thr 25/50: mag[4]=30, angle=0, mag[3]=60 -> 255; mag[3]=49, mag[5]=49 -> 0.
//  2 mode1: mag[4]=25, mag[8]=50 -> 255; mag[4]=24 & all nbrs 255 -> 0; mag[4]=50 -> 255.
//  3 backpressure: stream 8 beats, out_ready toggled 1010..
//    -> 8 outputs in order, held stable while stalled, in_ready=0 when both stages full.
//  4 cfg mid-frame: write 10/20 at beat 3 of 5-beat frame -> frame uses 25/50;
//    next frame uses 10/20. Write 40/30 -> cfg_err pulse, no change.
//  5 stats: 6-beat frame, 4 edges, 2 strong -> frame_done once on last accept,
//    stat_edges=4, stat_strong=2; next frame counts restart from 0.
//  6 rst asserted with 2 beats in flight -> out_valid=0 immediately;
//    thresholds 25/50; stat_*=0.

Source files
------------

// File: rtl/hyst_stream.sv
// hyst_stream: streaming hysteresis threshold stage with a 2-stage valid/ready pipeline and per-frame stats
// Ports: cfg_*_i write pending low/high/mode (cfg_err_o pulses when low > high),
//        in_*_i 3x3 magnitude window beat (index 4 = centre), out_*_o 0/255 edge pixel beat,
//        frame_done_o pulses after the last beat of a frame leaves, stat_*_o hold that frame's counts.
module hyst_stream #(
  parameter int BITS = 8,
  parameter int LOW_DEFAULT = 25,
  parameter int HIGH_DEFAULT = 50,
  parameter int CNT_BITS = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we_i,
  input  logic [BITS-1:0]     cfg_low_i,
  input  logic [BITS-1:0]     cfg_high_i,
  input  logic [1:0]          cfg_mode_i,
  output logic                cfg_err_o,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [9*BITS-1:0]   in_mag_i,
  input  logic [1:0]          in_angle_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [7:0]          out_pixel_o,
  output logic                out_last_o,
  output logic                frame_done_o,
  output logic [CNT_BITS-1:0] stat_edges_o,
  output logic [CNT_BITS-1:0] stat_strong_o
);
  logic [BITS-1:0] pend_low_q, pend_high_q, act_low_q, act_high_q, low, high;
  logic [1:0] pend_mode_q, act_mode_q, mode, angle_q, mode_q;
  logic frame_start_q, cfg_err_q, cfg_ok;
  logic s1_valid_q, c_hi_q, c_lo_q, last_q, c_hi_d, c_lo_d;
  logic [7:0] nb_hi_q, nb_hi_d, out_pixel_q;
  logic out_valid_q, out_last_q, out_hi_q, frame_done_q, nb, edge_d;
  logic [CNT_BITS-1:0] edge_cnt_q, strong_cnt_q, edge_cnt_d, strong_cnt_d, stat_edges_q, stat_strong_q;
  logic en1, en2, in_acc, out_acc;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] c, input logic inc);
    return (inc && !(&c)) ? c + 1'b1 : c;
  endfunction

  // neighbour slot j holds window index j for j<4 and j+1 otherwise (centre skipped)
  for (genvar i = 0; i < 8; i++) begin : g_nb
    assign nb_hi_d[i] = in_mag_i[(i < 4 ? i : i + 1) * BITS +: BITS] >= high;
  end

  always_comb begin
    en2 = !out_valid_q || out_ready_i;
    en1 = !s1_valid_q || en2;
    in_acc = in_valid_i && en1;
    out_acc = out_valid_q && out_ready_i;
    cfg_ok = cfg_low_i <= cfg_high_i;
    // the first beat of a frame already uses the pending config it latches
    low = frame_start_q ? pend_low_q : act_low_q;
    high = frame_start_q ? pend_high_q : act_high_q;
    mode = frame_start_q ? pend_mode_q : act_mode_q;
    c_hi_d = in_mag_i[4*BITS +: BITS] >= high;
    c_lo_d = in_mag_i[4*BITS +: BITS] >= low;
    // angle a pairs neighbour slots 3-a and 4+a
    nb = mode_q == 2'd1 ? |nb_hi_q :
         mode_q == 2'd2 ? 1'b0 :
         nb_hi_q[{1'b0, ~angle_q}] | nb_hi_q[{1'b1, angle_q}];
    edge_d = c_hi_q || (c_lo_q && nb);
    edge_cnt_d = sat_inc(edge_cnt_q, out_pixel_q == 8'hFF);
    strong_cnt_d = sat_inc(strong_cnt_q, out_hi_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_low_q <= BITS'(LOW_DEFAULT);
      pend_high_q <= BITS'(HIGH_DEFAULT);
      pend_mode_q <= 2'd0;
      act_low_q <= BITS'(LOW_DEFAULT);
      act_high_q <= BITS'(HIGH_DEFAULT);
      act_mode_q <= 2'd0;
      frame_start_q <= 1'b1;
      cfg_err_q <= 1'b0;
      s1_valid_q <= 1'b0;
      c_hi_q <= 1'b0;
      c_lo_q <= 1'b0;
      nb_hi_q <= '0;
      angle_q <= 2'd0;
      mode_q <= 2'd0;
      last_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pixel_q <= 8'h00;
      out_last_q <= 1'b0;
      out_hi_q <= 1'b0;
      frame_done_q <= 1'b0;
      edge_cnt_q <= '0;
      strong_cnt_q <= '0;
      stat_edges_q <= '0;
      stat_strong_q <= '0;
    end else begin
      cfg_err_q <= cfg_we_i && !cfg_ok;
      if (cfg_we_i && cfg_ok) begin
        pend_low_q <= cfg_low_i;
        pend_high_q <= cfg_high_i;
        pend_mode_q <= cfg_mode_i;
      end
      if (in_acc) begin
        frame_start_q <= in_last_i;
        act_low_q <= low;
        act_high_q <= high;
        act_mode_q <= mode;
        c_hi_q <= c_hi_d;
        c_lo_q <= c_lo_d;
        nb_hi_q <= nb_hi_d;
        angle_q <= in_angle_i;
        mode_q <= mode;
        last_q <= in_last_i;
      end
      if (en1) s1_valid_q <= in_valid_i;
      if (en2) out_valid_q <= s1_valid_q;
      if (en2 && s1_valid_q) begin
        out_pixel_q <= edge_d ? 8'hFF : 8'h00;
        out_last_q <= last_q;
        out_hi_q <= c_hi_q;
      end
      frame_done_q <= out_acc && out_last_q;
      if (out_acc) begin
        edge_cnt_q <= out_last_q ? '0 : edge_cnt_d;
        strong_cnt_q <= out_last_q ? '0 : strong_cnt_d;
        if (out_last_q) begin
          stat_edges_q <= edge_cnt_d;
          stat_strong_q <= strong_cnt_d;
        end
      end
    end
  end

  assign cfg_err_o = cfg_err_q;
  assign in_ready_o = en1;
  assign out_valid_o = out_valid_q;
  assign out_pixel_o = out_pixel_q;
  assign out_last_o = out_last_q;
  assign frame_done_o = frame_done_q;
  assign stat_edges_o = stat_edges_q;
  assign stat_strong_o = stat_strong_q;
endmodule
